ysyx_041461_ifu_pcgen: RTL and testbench

- Fetch-side PC generator and instruction-fetch requester. Consumes the writeback stage's redirect command, mtvec/mepc and mstatus/mie/mip; produces the fetched instruction stream for ID.
- Detects pending machine-timer interrupts and misaligned PCs, and injects them as trap-tagged bubbles.
- Returns the fetch-side ready that gates trap retirement in writeback.
- One outstanding instruction-memory request; one-entry output register toward ID.

---
 rtl/ysyx_041461_ifu_pcgen.sv | 156 +++++++++++++++
 tb/tb_ysyx_041461_ifu_pcgen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_ifu_pcgen.sv
// rtl/ysyx_041461_ifu_pcgen.sv - fetch PC generator, single-outstanding imem requester, trap-bubble injector
// One output entry toward ID; redirects flush it and orphan any in-flight response via drop_q.
module ysyx_041461_ifu_pcgen #(
   parameter logic [63:0] RESET_PC         = 64'h8000_0000,
   parameter logic [1:0]  CTRL_NOP         = 2'b00,
   parameter logic [1:0]  CTRL_MTVEC       = 2'b01,
   parameter logic [1:0]  CTRL_MEPC        = 2'b10,
   parameter logic [3:0]  TRAP_NOP         = 4'd0,
   parameter logic [3:0]  TRAP_IF_MISALIGN = 4'd1,
   parameter logic [3:0]  TRAP_TIMER_INT   = 4'd8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wb_ctrl,
   input  logic [63:0] wb_mtvec,
   input  logic [63:0] wb_mepc,
   input  logic [63:0] wb_mstatus,
   input  logic [63:0] wb_mie,
   input  logic [63:0] wb_mip,
   output logic        if_ready,
   input  logic        exe_redir_valid,
   input  logic [63:0] exe_redir_pc,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [63:0] id_pc,
   output logic [3:0]  id_trap,
   input  logic        id_ready
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic        int_pend_q, int_pend_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [63:0] id_pc_q, id_pc_d;
   logic [3:0]  id_trap_q, id_trap_d;

   logic        wb_any, wb_redir, exe_redir, redir;
   logic        irq, misalign, slot_free, can_issue;
   logic [63:0] redir_pc;
   logic        unused_bits;

   assign if_ready  = ~((state_q == ST_WAIT) & drop_q);
   // A held writeback trap (if_ready low) also masks any EXE redirect behind it.
   assign wb_any    = (wb_ctrl != CTRL_NOP) & if_ready;
   assign wb_redir  = ((wb_ctrl == CTRL_MTVEC) | (wb_ctrl == CTRL_MEPC)) & if_ready;
   assign exe_redir = exe_redir_valid & (wb_ctrl == CTRL_NOP);
   assign redir     = wb_redir | exe_redir;
   assign redir_pc  = (wb_ctrl == CTRL_MTVEC) ? {wb_mtvec[63:2], 2'b00} :
                      (wb_ctrl == CTRL_MEPC)  ? wb_mepc : exe_redir_pc;

   assign irq       = wb_mstatus[3] & wb_mie[7] & wb_mip[7] & ~int_pend_q;
   assign misalign  = (pc_q[1:0] != 2'b00);
   assign slot_free = ~id_valid_q | id_ready;
   assign can_issue = (state_q == ST_REQ) & slot_free & ~int_pend_q & ~redir;

   assign imem_req_valid = can_issue & ~irq & ~misalign & ~rst;
   assign imem_req_addr  = pc_q;

   assign id_valid = id_valid_q;
   assign id_inst  = id_inst_q;
   assign id_pc    = id_pc_q;
   assign id_trap  = id_trap_q;

   assign unused_bits = ^{wb_mstatus[63:4], wb_mstatus[2:0], wb_mie[63:8], wb_mie[6:0],
                          wb_mip[63:8], wb_mip[6:0], wb_mtvec[1:0]};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      int_pend_d = int_pend_q;
      id_valid_d = id_valid_q & ~id_ready;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      id_trap_d  = id_trap_q;

      case (state_q)
         ST_REQ: begin
            if (can_issue & (irq | misalign)) begin
               id_valid_d = 1'b1;
               id_inst_d  = NOP_INST;
               id_pc_d    = pc_q;
               id_trap_d  = irq ? TRAP_TIMER_INT : TRAP_IF_MISALIGN;
               int_pend_d = 1'b1;
            end else if (imem_req_valid & imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q | redir) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  id_valid_d = 1'b1;
                  id_inst_d  = imem_rsp_data;
                  id_pc_d    = pc_q;
                  id_trap_d  = TRAP_NOP;
                  pc_d       = pc_q + 64'd4;
                  state_d    = ST_HOLD;
               end
            end else if (redir) begin
               drop_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (id_ready | redir) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase

      if (redir) begin
         pc_d       = redir_pc;
         id_valid_d = 1'b0;
      end
      if (wb_any) begin
         int_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         int_pend_q <= 1'b0;
         id_valid_q <= 1'b0;
         id_inst_q  <= 32'h0;
         id_pc_q    <= 64'h0;
         id_trap_q  <= TRAP_NOP;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         int_pend_q <= int_pend_d;
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         id_trap_q  <= id_trap_d;
      end
   end

endmodule

// File: tb/tb_ysyx_041461_ifu_pcgen.sv
// tb/tb_ysyx_041461_ifu_pcgen.sv - directed and randomized bench for ysyx_041461_ifu_pcgen
// Memory responder and ID-stream reference model run inside the per-cycle task.
module tb_ysyx_041461_ifu_pcgen;

   logic        clk;
   logic        rst;
   logic [1:0]  wb_ctrl;
   logic [63:0] wb_mtvec, wb_mepc, wb_mstatus, wb_mie, wb_mip;
   logic        if_ready;
   logic        exe_redir_valid;
   logic [63:0] exe_redir_pc;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [63:0] id_pc;
   logic [3:0]  id_trap;
   logic        id_ready;

   ysyx_041461_ifu_pcgen dut (
      .clk(clk), .rst(rst), .wb_ctrl(wb_ctrl), .wb_mtvec(wb_mtvec), .wb_mepc(wb_mepc),
      .wb_mstatus(wb_mstatus), .wb_mie(wb_mie), .wb_mip(wb_mip), .if_ready(if_ready),
      .exe_redir_valid(exe_redir_valid), .exe_redir_pc(exe_redir_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_inst(id_inst),
      .id_pc(id_pc), .id_trap(id_trap), .id_ready(id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // memory model and observation state
   logic        mem_rand, pend, stream_chk;
   int          mem_lat, cnt;
   logic [63:0] pend_addr, exp_pc;
   logic        acc, xfer;
   logic [63:0] acc_addr;
   int          n_reqv, n_xfer;
   logic        m_if_ready, m_id_valid;
   logic [31:0] m_id_inst;
   logic [63:0] m_id_pc;
   logic [3:0]  m_id_trap;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      if (a == 64'h8000_0000) return 32'h0010_0093;
      return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs already set by the caller at the preceding negedge.
   task automatic cycle();
      imem_req_ready = mem_rand ? ($urandom_range(3) != 0) : 1'b1;
      imem_rsp_valid = pend && (cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? inst_of(pend_addr) : $urandom;
      #1;
      m_if_ready = if_ready;
      m_id_valid = id_valid;
      m_id_inst  = id_inst;
      m_id_pc    = id_pc;
      m_id_trap  = id_trap;
      acc  = 1'b0;
      xfer = 1'b0;
      if (imem_rsp_valid) pend = 1'b0;
      else if (pend) cnt--;
      if (imem_req_valid) n_reqv++;
      if (imem_req_valid && imem_req_ready) begin
         check("one_outstanding", 64'(pend), 64'd0);
         pend      = 1'b1;
         pend_addr = imem_req_addr;
         cnt       = mem_rand ? int'($urandom_range(3)) : mem_lat;
         acc       = 1'b1;
         acc_addr  = imem_req_addr;
      end
      if (id_valid && id_ready) begin
         xfer = 1'b1;
         n_xfer++;
         if (stream_chk) begin
            check("stream_pc", id_pc, exp_pc);
            check("stream_inst", 64'(id_inst), 64'(inst_of(exp_pc)));
            check("stream_trap", 64'(id_trap), 64'd0);
            exp_pc = exp_pc + 64'd4;
         end
      end
      if (stream_chk && exe_redir_valid && wb_ctrl == 2'b00) exp_pc = exe_redir_pc;
      @(negedge clk);
   endtask

   task automatic wait_req(input string tag, output logic [63:0] addr, output int n);
      n = 0;
      do begin cycle(); n++; end while (!acc && n < 50);
      check({tag, "_seen"}, 64'(acc), 64'd1);
      addr = acc_addr;
   endtask

   task automatic wait_xfer(input string tag, output int n);
      n = 0;
      do begin cycle(); n++; end while (!xfer && n < 50);
      check({tag, "_seen"}, 64'(xfer), 64'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin cycle(); n++; end while (!m_id_valid && n < 50);
      check({tag, "_seen"}, 64'(m_id_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] a, p;
      logic [31:0] ins;
      int n, r0, x0;

      rst = 1'b1; wb_ctrl = 2'b00; wb_mtvec = '0; wb_mepc = '0;
      wb_mstatus = '0; wb_mie = '0; wb_mip = '0;
      exe_redir_valid = 1'b0; exe_redir_pc = '0; id_ready = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      mem_rand = 1'b0; mem_lat = 0; cnt = 0; pend = 1'b0; stream_chk = 1'b0;
      exp_pc = '0; acc = 1'b0; xfer = 1'b0; acc_addr = '0; pend_addr = '0;
      n_reqv = 0; n_xfer = 0;

      // reset values
      @(negedge clk); @(negedge clk); #1;
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_req_addr", imem_req_addr, 64'h8000_0000);
      check("rst_id_valid", 64'(id_valid), 64'd0);
      check("rst_id_inst", 64'(id_inst), 64'd0);
      check("rst_id_pc", id_pc, 64'd0);
      check("rst_id_trap", 64'(id_trap), 64'd0);
      check("rst_if_ready", 64'(if_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // first fetch after reset
      wait_req("s1_req", a, n);
      check("s1_req_addr", a, 64'h8000_0000);
      check("s1_req_lat", 64'(n), 64'd1);
      wait_xfer("s1_id", n);
      check("s1_id_lat", 64'(n), 64'd2);
      check("s1_id_pc", m_id_pc, 64'h8000_0000);
      check("s1_id_trap", 64'(m_id_trap), 64'd0);
      check("s1_id_inst", 64'(m_id_inst), 64'h0010_0093);
      wait_req("s1_req2", a, n);
      check("s1_req2_addr", a, 64'h8000_0004);
      check("s1_req2_lat", 64'(n), 64'd1);

      // timer interrupt bubble, then mtvec redirect
      wb_mstatus = 64'h8; wb_mie = 64'h80; wb_mip = 64'h80;
      wait_xfer("s2_seq", n);
      check("s2_seq_pc", m_id_pc, 64'h8000_0004);
      check("s2_seq_trap", 64'(m_id_trap), 64'd0);
      wait_xfer("s2_irq", n);
      check("s2_irq_pc", m_id_pc, 64'h8000_0008);
      check("s2_irq_trap", 64'(m_id_trap), 64'd8);
      check("s2_irq_inst", 64'(m_id_inst), 64'h13);
      r0 = n_reqv;
      repeat (8) cycle();
      check("s2_no_req", 64'(n_reqv - r0), 64'd0);
      wb_ctrl = 2'b01; wb_mtvec = 64'h8000_0100; wb_mstatus = 64'h0;
      cycle();
      wb_ctrl = 2'b00;
      wait_req("s2_mtvec", a, n);
      check("s2_mtvec_addr", a, 64'h8000_0100);

      // misaligned EXE target landing on the response cycle
      exe_redir_valid = 1'b1; exe_redir_pc = 64'h8000_0202;
      cycle();
      exe_redir_valid = 1'b0;
      cycle();
      check("s3_no_drop", 64'(m_if_ready), 64'd1);
      wait_xfer("s3_mis", n);
      check("s3_mis_pc", m_id_pc, 64'h8000_0202);
      check("s3_mis_trap", 64'(m_id_trap), 64'd1);
      check("s3_mis_inst", 64'(m_id_inst), 64'h13);
      r0 = n_reqv;
      repeat (5) cycle();
      check("s3_no_req", 64'(n_reqv - r0), 64'd0);

      // mepc redirect while waiting; second trap held off by if_ready
      mem_lat = 4;
      wb_ctrl = 2'b01; wb_mtvec = 64'h8000_0200;
      cycle();
      wb_ctrl = 2'b00;
      wait_req("s4_req", a, n);
      check("s4_req_addr", a, 64'h8000_0200);
      x0 = n_xfer;
      wb_ctrl = 2'b10; wb_mepc = 64'h8000_0040;
      cycle();
      check("s4_if_ready_first", 64'(m_if_ready), 64'd1);
      wb_ctrl = 2'b01; wb_mtvec = 64'h8000_0100;
      cycle();
      check("s4_if_ready_held", 64'(m_if_ready), 64'd0);
      wb_ctrl = 2'b00; mem_lat = 0;
      wait_req("s4_req2", a, n);
      check("s4_req2_addr", a, 64'h8000_0040);
      check("s4_discarded", 64'(n_xfer - x0), 64'd0);

      // ID backpressure
      id_ready = 1'b0;
      wait_valid("s5_valid");
      p = m_id_pc; ins = m_id_inst;
      check("s5_pc", p, 64'h8000_0040);
      r0 = n_reqv;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("s5_hold_valid", 64'(m_id_valid), 64'd1);
         check("s5_hold_pc", m_id_pc, p);
         check("s5_hold_inst", 64'(m_id_inst), 64'(ins));
      end
      check("s5_no_req", 64'(n_reqv - r0), 64'd0);
      id_ready = 1'b1;
      cycle();
      check("s5_xfer", 64'(xfer), 64'd1);
      wait_req("s5_req", a, n);
      check("s5_req_addr", a, 64'h8000_0044);
      check("s5_req_lat", 64'(n), 64'd1);

      // writeback beats EXE; mtvec low bits cleared
      wb_ctrl = 2'b01; wb_mtvec = 64'h8000_0103;
      exe_redir_valid = 1'b1; exe_redir_pc = 64'h8000_0500;
      cycle();
      wb_ctrl = 2'b00; exe_redir_valid = 1'b0;
      wait_req("s6_req", a, n);
      check("s6_req_addr", a, 64'h8000_0100);

      // reset mid-transaction; stale response must be ignored
      wait_xfer("s7_pre", n);
      check("s7_pre_pc", m_id_pc, 64'h8000_0100);
      mem_lat = 1;
      wait_req("s7_req", a, n);
      check("s7_req_addr", a, 64'h8000_0104);
      rst = 1'b1;
      cycle();
      rst = 1'b0; mem_lat = 0;
      wait_xfer("s7_id", n);
      check("s7_id_pc", m_id_pc, 64'h8000_0000);
      check("s7_id_inst", 64'(m_id_inst), 64'h0010_0093);
      check("s7_id_trap", 64'(m_id_trap), 64'd0);

      // randomized traffic against the stream model, starting with a 64-bit wrap
      exp_pc = 64'h8000_0004;
      stream_chk = 1'b1; mem_rand = 1'b1;
      x0 = n_xfer;
      for (int i = 0; i < 800; i++) begin
         id_ready = ($urandom_range(3) != 0);
         exe_redir_valid = (i == 0) || (i > 20 && $urandom_range(15) == 0);
         exe_redir_pc = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                 : ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC);
         cycle();
      end
      exe_redir_valid = 1'b0;
      check("s8_progress", 64'(n_xfer - x0 >= 40), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
